// File: rtl/bus_ctrl_pkg.sv
// Shared types and constants for the bus sequencing FSM.
// Contents: FSM state enum, opcode class constants, HALT opcode and a decode helper.
package bus_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StAddr,
    StExecLd,
    StExecSt,
    StHalted
  } state_e;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_LD  = 2'b01;
  localparam logic [1:0] OP_ST  = 2'b10;
  localparam logic [1:0] OP_SYS = 2'b11;

  localparam logic [7:0] HALT_CODE = 8'hFF;

  // Class 11 is only legal as the exact HALT encoding.
  function automatic logic is_halt(input logic [7:0] op);
    return op == HALT_CODE;
  endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter: ADDR_W-bit register with increment enable.
// Wraps naturally from all-ones to zero; cleared only by the asynchronous reset.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low clear
//   inc   - advance by one at the next rising edge
//   pc    - current program counter
module program_counter #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] PcOne = {{(ADDR_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (inc) begin
      pc <= pc + PcOne;
    end
  end

endmodule

// File: rtl/bus_controller.sv
// Fetch/decode/execute sequencer for the shared 8-bit processor bus.
// Owns all bus enable/load strobes and the memory address; outputs are Moore
// (decoded from the state register only) so at most one bus driver is ever active.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   start                 - leave IDLE/HALTED and fetch at pc (ignored while busy)
//   opcode                - opcode register contents
//   bus_value             - current bus contents (operand address source)
//   mem_ready             - memory access completes at this edge
//   memory_enable/_load   - memory drives / captures the bus
//   opcode_reg_load       - opcode register captures the bus
//   register_bank_enable  - register bank drives the bus
//   register_bank_load    - register bank captures the bus
//   mem_addr, reg_sel, pc - memory address, register select, program counter
//   busy, halted, illegal - status (illegal is sticky until restart)
module bus_controller
  import bus_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned REG_SEL_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           opcode,
  input  logic [7:0]           bus_value,
  input  logic                 mem_ready,
  output logic                 memory_enable,
  output logic                 memory_load,
  output logic                 opcode_reg_load,
  output logic                 register_bank_enable,
  output logic                 register_bank_load,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [REG_SEL_W-1:0] reg_sel,
  output logic [ADDR_W-1:0]    pc,
  output logic                 busy,
  output logic                 halted,
  output logic                 illegal
);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q;
  logic [REG_SEL_W-1:0]  reg_sel_q;
  logic                  is_ld_q;
  logic                  illegal_q;

  logic pc_inc;
  logic addr_capture;
  logic decode_capture;
  logic illegal_set;
  logic illegal_clr;

  program_counter #(
    .ADDR_W(ADDR_W)
  ) u_program_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (pc_inc),
    .pc   (pc)
  );

  always_comb begin
    state_d              = state_q;
    memory_enable        = 1'b0;
    memory_load          = 1'b0;
    opcode_reg_load      = 1'b0;
    register_bank_enable = 1'b0;
    register_bank_load   = 1'b0;
    mem_addr             = '0;
    pc_inc               = 1'b0;
    addr_capture         = 1'b0;
    decode_capture       = 1'b0;
    illegal_set          = 1'b0;
    illegal_clr          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        mem_addr        = pc;
        memory_enable   = 1'b1;
        opcode_reg_load = 1'b1;
        if (mem_ready) begin
          pc_inc  = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        decode_capture = 1'b1;
        unique case (opcode[7:6])
          OP_NOP:  state_d = StFetch;
          OP_LD:   state_d = StAddr;
          OP_ST:   state_d = StAddr;
          default: begin
            state_d     = StHalted;
            illegal_set = !is_halt(opcode);
          end
        endcase
      end
      StAddr: begin
        mem_addr      = pc;
        memory_enable = 1'b1;
        if (mem_ready) begin
          pc_inc       = 1'b1;
          addr_capture = 1'b1;
          state_d      = is_ld_q ? StExecLd : StExecSt;
        end
      end
      StExecLd: begin
        mem_addr           = addr_q;
        memory_enable      = 1'b1;
        register_bank_load = 1'b1;
        if (mem_ready) state_d = StFetch;
      end
      StExecSt: begin
        mem_addr             = addr_q;
        register_bank_enable = 1'b1;
        memory_load          = 1'b1;
        if (mem_ready) state_d = StFetch;
      end
      StHalted: begin
        if (start) begin
          illegal_clr = 1'b1;
          state_d     = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      reg_sel_q <= '0;
      is_ld_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (addr_capture) addr_q <= ADDR_W'(bus_value);
      if (decode_capture) begin
        reg_sel_q <= REG_SEL_W'(opcode[5:4]);
        // The opcode register is not reloaded until the next fetch, but the
        // class is latched here so ADDR does not depend on that.
        is_ld_q   <= (opcode[7:6] == OP_LD);
      end
      if (illegal_set) begin
        illegal_q <= 1'b1;
      end else if (illegal_clr) begin
        illegal_q <= 1'b0;
      end
    end
  end

  assign reg_sel = reg_sel_q;
  assign illegal = illegal_q;
  assign halted  = (state_q == StHalted);
  assign busy    = (state_q != StIdle) && (state_q != StHalted);

endmodule

// File: tb/tb_bus_controller.sv
// Directed bench for bus_controller with a small memory / register-bank /
// opcode-register model and a configurable number of wait states.
module tb_bus_controller;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned REG_SEL_W = 2;

  localparam logic [4:0] S_NONE  = 5'b00000;
  localparam logic [4:0] S_FETCH = 5'b10100;
  localparam logic [4:0] S_ADDR  = 5'b10000;
  localparam logic [4:0] S_LD    = 5'b10001;
  localparam logic [4:0] S_ST    = 5'b01010;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [7:0]           opcode;
  logic [7:0]           bus_value;
  logic                 mem_ready;
  logic                 memory_enable;
  logic                 memory_load;
  logic                 opcode_reg_load;
  logic                 register_bank_enable;
  logic                 register_bank_load;
  logic [ADDR_W-1:0]    mem_addr;
  logic [REG_SEL_W-1:0] reg_sel;
  logic [ADDR_W-1:0]    pc;
  logic                 busy;
  logic                 halted;
  logic                 illegal;

  int n_checks = 0;
  int n_fail   = 0;

  bus_controller #(
    .ADDR_W   (ADDR_W),
    .REG_SEL_W(REG_SEL_W)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .opcode              (opcode),
    .bus_value           (bus_value),
    .mem_ready           (mem_ready),
    .memory_enable       (memory_enable),
    .memory_load         (memory_load),
    .opcode_reg_load     (opcode_reg_load),
    .register_bank_enable(register_bank_enable),
    .register_bank_load  (register_bank_load),
    .mem_addr            (mem_addr),
    .reg_sel             (reg_sel),
    .pc                  (pc),
    .busy                (busy),
    .halted              (halted),
    .illegal             (illegal)
  );

  always #5 clk = ~clk;

  // ---------------- environment model ----------------
  logic [7:0]  img      [256];
  logic [7:0]  mem      [256];
  logic [7:0]  reg_init [4];
  logic [7:0]  regs     [4];
  logic [7:0]  opcode_q;
  logic        load_img;
  logic        stall;
  int unsigned wait_n;
  int unsigned cnt;
  logic        active;

  assign active    = memory_enable | memory_load;
  assign mem_ready = active && !stall && (cnt == wait_n);
  assign opcode    = opcode_q;

  always_comb begin
    bus_value = 8'h00;
    if (memory_enable)             bus_value = mem[mem_addr];
    else if (register_bank_enable) bus_value = regs[reg_sel];
  end

  always @(posedge clk) begin
    if (load_img) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
      for (int i = 0; i < 4; i++) regs[i] <= reg_init[i];
      opcode_q <= 8'h00;
      cnt      <= 0;
    end else begin
      cnt <= (mem_ready || !active) ? 0 : cnt + 1;
      if (mem_ready && memory_load)        mem[mem_addr]  <= bus_value;
      if (mem_ready && register_bank_load) regs[reg_sel]  <= bus_value;
      if (mem_ready && opcode_reg_load)    opcode_q       <= bus_value;
    end
  end

  logic [4:0]  strobes;
  logic [25:0] all_outs;
  assign strobes  = {memory_enable, memory_load, opcode_reg_load,
                     register_bank_enable, register_bank_load};
  assign all_outs = {strobes, mem_addr, reg_sel, pc, busy, halted, illegal};

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("one_driver", 32'(memory_enable & register_bank_enable), 32'd0);
      check("one_loader", 32'(memory_load & register_bank_load), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    for (int i = 0; i < 4; i++) reg_init[i] = 8'h00;
  endtask

  task automatic do_reset(input int unsigned w);
    rst_n    = 1'b0;
    start    = 1'b0;
    stall    = 1'b0;
    wait_n   = w;
    load_img = 1'b1;
    @(negedge clk);
    @(negedge clk);
    load_img = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_halted(input int max_cycles);
    int n = 0;
    while (!halted && n < max_cycles) begin
      tick();
      n++;
    end
    check("halt_reached", 32'(halted), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    rst_n    = 1'b0;
    start    = 1'b0;
    stall    = 1'b0;
    wait_n   = 0;
    load_img = 1'b1;
    clear_img();

    // 1: reset held while start toggles
    for (int i = 0; i < 4; i++) begin
      start = ~start;
      @(negedge clk);
      check("reset_outs", 32'(all_outs), 32'd0);
    end
    load_img = 1'b0;
    start    = 1'b0;
    rst_n    = 1'b1;
    tick();
    check("idle_after_reset", 32'({strobes, busy}), 32'd0);

    // 2: {00, FF}, zero wait
    clear_img();
    img[0] = 8'h00;
    img[1] = 8'hFF;
    do_reset(0);
    start_pulse();
    check("t2_fetch0_strb", 32'(strobes), 32'(S_FETCH));
    check("t2_fetch0_addr", 32'(mem_addr), 32'h00);
    tick();
    check("t2_dec0_strb", 32'(strobes), 32'(S_NONE));
    check("t2_dec0_pc", 32'(pc), 32'd1);
    tick();
    check("t2_fetch1_strb", 32'(strobes), 32'(S_FETCH));
    check("t2_fetch1_addr", 32'(mem_addr), 32'h01);
    tick();
    check("t2_dec1_strb", 32'(strobes), 32'(S_NONE));
    tick();
    check("t2_halted", 32'(halted), 32'd1);
    check("t2_pc", 32'(pc), 32'd2);
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_strb", 32'(strobes), 32'(S_NONE));

    // 3: LD r1,[3C] with two wait states per access
    clear_img();
    img[0]     = 8'h50;
    img[1]     = 8'h3C;
    img[2]     = 8'hFF;
    img[8'h3C] = 8'h5A;
    do_reset(2);
    start_pulse();
    for (int k = 0; k < 3; k++) begin
      check("t3_fetch_strb", 32'(strobes), 32'(S_FETCH));
      tick();
    end
    check("t3_dec_strb", 32'(strobes), 32'(S_NONE));
    check("t3_dec_pc", 32'(pc), 32'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      check("t3_addr_strb", 32'(strobes), 32'(S_ADDR));
      check("t3_addr_addr", 32'(mem_addr), 32'h01);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      check("t3_ld_strb", 32'(strobes), 32'(S_LD));
      check("t3_ld_addr", 32'(mem_addr), 32'h3C);
      check("t3_ld_sel", 32'(reg_sel), 32'd1);
      tick();
    end
    check("t3_after_strb", 32'(strobes), 32'(S_FETCH));
    check("t3_after_pc", 32'(pc), 32'd2);
    check("t3_reg1", 32'(regs[1]), 32'h5A);
    wait_halted(20);

    // 4: ST r2,[10]
    clear_img();
    img[0]      = 8'hA0;
    img[1]      = 8'h10;
    img[2]      = 8'hFF;
    reg_init[2] = 8'hC3;
    do_reset(0);
    start_pulse();
    tick();
    tick();
    check("t4_addr_strb", 32'(strobes), 32'(S_ADDR));
    check("t4_addr_addr", 32'(mem_addr), 32'h01);
    tick();
    check("t4_st_strb", 32'(strobes), 32'(S_ST));
    check("t4_st_men", 32'(memory_enable), 32'd0);
    check("t4_st_addr", 32'(mem_addr), 32'h10);
    check("t4_st_sel", 32'(reg_sel), 32'd2);
    check("t4_st_bus", 32'(bus_value), 32'hC3);
    tick();
    check("t4_mem10", 32'(mem[8'h10]), 32'hC3);
    check("t4_pc", 32'(pc), 32'd2);
    wait_halted(10);

    // 5: illegal opcode C1, then restart
    clear_img();
    img[0] = 8'hC1;
    img[1] = 8'hFF;
    do_reset(0);
    start_pulse();
    tick();
    tick();
    check("t5_illegal", 32'(illegal), 32'd1);
    check("t5_halted", 32'(halted), 32'd1);
    check("t5_pc", 32'(pc), 32'd1);
    start_pulse();
    check("t5_illegal_clr", 32'(illegal), 32'd0);
    check("t5_fetch_addr", 32'(mem_addr), 32'h01);
    check("t5_busy", 32'(busy), 32'd1);
    wait_halted(10);
    check("t5_illegal_end", 32'(illegal), 32'd0);
    check("t5_pc_end", 32'(pc), 32'd2);

    // 6a: NOP stream up to pc=FF, next fetch wraps to 00
    clear_img();
    do_reset(0);
    start_pulse();
    found = 1'b0;
    for (int n = 0; n < 700 && !found; n++) begin
      if (pc == 8'hFF && strobes == S_FETCH) found = 1'b1;
      else tick();
    end
    check("t6_reach_ff", 32'(found), 32'd1);
    tick();
    check("t6_pc_wrap", 32'(pc), 32'h00);

    // 6b: reset in the middle of a stalled EXEC_LD
    clear_img();
    img[0]     = 8'h50;
    img[1]     = 8'h3C;
    img[8'h3C] = 8'h5A;
    do_reset(0);
    start_pulse();
    tick();
    tick();
    tick();
    check("t6_ld_strb", 32'(strobes), 32'(S_LD));
    stall = 1'b1;
    tick();
    check("t6_ld_hold", 32'(strobes), 32'(S_LD));
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_outs", 32'(all_outs), 32'd0);
    repeat (3) tick();
    check("t6_rst_strb", 32'(strobes), 32'(S_NONE));
    check("t6_no_load", 32'(regs[1]), 32'h00);
    stall = 1'b0;
    rst_n = 1'b1;
    tick();
    check("t6_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
